// File: rtl/wb_write_port.sv
// Register file write port: MEM/WB stage register with MemtoReg select, plus an
// auxiliary result queue that drains into the port whenever the pipeline leaves it idle.
module wb_write_port #(
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_RegWrite,
  input  logic        mem_MemtoReg,
  input  logic [4:0]  mem_WN,
  input  logic [31:0] mem_ALUout,
  input  logic [31:0] mem_RD,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_WN,
  input  logic [31:0] aux_WD,
  output logic        RegWrite,
  output logic [4:0]  WN,
  output logic [31:0] WD,
  input  logic [4:0]  RN1,
  input  logic [4:0]  RN2,
  output logic        fwd1,
  output logic        fwd2,
  output logic [31:0] fwd_data1,
  output logic [31:0] fwd_data2,
  output logic        pend1,
  output logic        pend2
);

  localparam int DEPTH = 2 ** PTR_W;
  localparam int CNT_W = PTR_W + 1;

  logic             wb_rw_r;
  logic [4:0]       wb_wn_r;
  logic [31:0]      wb_wd_r;
  logic [DEPTH-1:0] live_r;
  logic [4:0]       q_wn_r [DEPTH];
  logic [31:0]      q_wd_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  logic pipe_valid_s;
  logic not_empty_s;
  logic head_live_s;
  logic pop_s;
  logic push_s;

  assign pipe_valid_s = wb_rw_r && (wb_wn_r != 5'd0);
  assign not_empty_s  = (count_r != {CNT_W{1'b0}});
  assign head_live_s  = not_empty_s && live_r[head_r];
  // A killed head is dropped even while the pipeline owns the port.
  assign pop_s        = not_empty_s && (!pipe_valid_s || !live_r[head_r]);
  assign aux_ready    = (count_r != CNT_W'(DEPTH)) && rst_n;
  assign push_s       = aux_valid && aux_ready && (aux_WN != 5'd0);

  // MEM/WB pipeline register, MemtoReg select applied on entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rw_r <= 1'b0;
      wb_wn_r <= 5'd0;
      wb_wd_r <= 32'd0;
    end else begin
      wb_rw_r <= mem_RegWrite;
      wb_wn_r <= mem_WN;
      wb_wd_r <= mem_MemtoReg ? mem_RD : mem_ALUout;
    end
  end

  // Aux queue: WAW kill, then pop, then push so a same-cycle push is never killed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_r  <= {DEPTH{1'b0}};
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        q_wn_r[i] <= 5'd0;
        q_wd_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_valid_s && (q_wn_r[i] == wb_wn_r)) begin
          live_r[i] <= 1'b0;
        end
      end
      if (pop_s) begin
        live_r[head_r] <= 1'b0;
        head_r         <= head_r + 1'b1;
      end
      if (push_s) begin
        live_r[tail_r] <= 1'b1;
        q_wn_r[tail_r] <= aux_WN;
        q_wd_r[tail_r] <= aux_WD;
        tail_r         <= tail_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Port arbitration: pipeline first, live queue head second
  always_comb begin
    RegWrite = 1'b0;
    WN       = 5'd0;
    WD       = 32'd0;
    if (pipe_valid_s) begin
      RegWrite = 1'b1;
      WN       = wb_wn_r;
      WD       = wb_wd_r;
    end else if (head_live_s) begin
      RegWrite = 1'b1;
      WN       = q_wn_r[head_r];
      WD       = q_wd_r[head_r];
    end else begin
      RegWrite = 1'b0;
    end
  end

  // Decode-side bypass of this cycle's write
  always_comb begin
    fwd1      = RegWrite && (WN == RN1) && (RN1 != 5'd0);
    fwd2      = RegWrite && (WN == RN2) && (RN2 != 5'd0);
    fwd_data1 = 32'd0;
    fwd_data2 = 32'd0;
    if (fwd1) begin
      fwd_data1 = WD;
    end else begin
      fwd_data1 = 32'd0;
    end
    if (fwd2) begin
      fwd_data2 = WD;
    end else begin
      fwd_data2 = 32'd0;
    end
  end

  // Pending flags: live queued entries only
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_r[i] && (q_wn_r[i] == RN1) && (RN1 != 5'd0)) begin
        pend1 = 1'b1;
      end else begin
        pend1 = pend1;
      end
      if (live_r[i] && (q_wn_r[i] == RN2) && (RN2 != 5'd0)) begin
        pend2 = 1'b1;
      end else begin
        pend2 = pend2;
      end
    end
  end

endmodule
